// File: rtl/crc_feeder_pkg.sv
// crc_feeder_pkg
// Shared definitions for the CRC-32/MPEG-2 frame feeder:
//   - feeder_state_e : feeder FSM states (also exported on the debug port)
//   - CRC_INIT       : engine register value while held in reset
//   - CRC_POLY       : MPEG-2 generator polynomial (non-reflected)
//   - CRC_RESIDUE    : engine value after a frame plus its own CRC
//   - BITS_PER_BYTE  : serialisation length per accepted byte
package crc_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } feeder_state_e;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_RESIDUE   = 32'h0000_0000;
  localparam int          BITS_PER_BYTE = 8;

endpackage

// File: rtl/byte_serializer.sv
// byte_serializer
// Holds one byte and presents it MSB-first, one bit per shift cycle.
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   load           : capture byte_in, restart the bit count
//   byte_in [7:0]  : byte to serialise
//   shift          : advance to the next bit
//   bit_out        : current bit (bit 7 of the held byte first)
//   last_bit       : the bit on bit_out is the final bit of the byte
module byte_serializer
  import crc_feeder_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       shift,
  output logic       bit_out,
  output logic       last_bit
);

  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else if (load) begin
      shift_q   <= byte_in;
      bit_cnt_q <= 3'd0;
    end else if (shift) begin
      shift_q   <= {shift_q[6:0], 1'b0};
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  assign bit_out  = shift_q[7];
  assign last_bit = (bit_cnt_q == 3'(BITS_PER_BYTE - 1));

endmodule

// File: rtl/crc_frame_feeder.sv
// crc_frame_feeder
// Accepts a framed byte stream and feeds it MSB-first into a bit-serial
// CRC-32/MPEG-2 engine, resetting the engine between frames and capturing
// the final CRC and the frame byte count.
//
// Handshake: a byte is accepted on a rising clk_in edge where
// byte_valid_in and byte_ready_out are both high; byte_in and byte_last_in
// are only looked at on that edge. byte_ready_out never depends on
// byte_valid_in, and valid may drop or stay low for any number of cycles.
//
// Ports:
//   clk_in, rst_in        : clock, synchronous active-high reset
//   byte_in/valid/last    : upstream byte stream
//   byte_ready_out        : feeder can accept a byte this cycle
//   crc_rst_out           : engine reset (held high while idle)
//   crc_valid_out/bit_out : engine serial data interface
//   crc_in                : engine CRC register
//   crc_out, len_out      : captured CRC and byte count (saturating)
//   done_out              : one-cycle pulse when crc_out/len_out update
//   crc_ok_out            : residue check, only when CRC_CHECK_EN is defined
//   dbg_state             : current FSM state for observation
// Build option: define CRC_CHECK_EN to add crc_ok_out.
module crc_frame_feeder
  import crc_feeder_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid_in,
  input  logic             byte_last_in,
  output logic             byte_ready_out,
  output logic             crc_rst_out,
  output logic             crc_valid_out,
  output logic             crc_bit_out,
  input  logic [31:0]      crc_in,
  output logic [31:0]      crc_out,
  output logic [LEN_W-1:0] len_out,
  output logic             done_out,
`ifdef CRC_CHECK_EN
  output logic             crc_ok_out,
`endif
  output feeder_state_e    dbg_state
);

  feeder_state_e    state_q, state_nx;
  logic             ready_st;
  logic             accept;
  logic             ser_load, ser_shift, ser_bit, ser_last;
  logic             last_q;
  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] count_base;
  logic [LEN_W-1:0] count_inc;

  byte_serializer u_ser (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (ser_load),
    .byte_in  (byte_in),
    .shift    (ser_shift),
    .bit_out  (ser_bit),
    .last_bit (ser_last)
  );

  // Ready is a pure state decode; it is additionally forced low while
  // reset is asserted so nothing looks acceptable during reset.
  assign ready_st       = (state_q == ST_IDLE) || (state_q == ST_WAIT);
  assign byte_ready_out = ready_st & ~rst_in;
  assign accept         = byte_valid_in & byte_ready_out;
  assign ser_load       = accept;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx      = state_q;
    crc_rst_out   = 1'b0;
    crc_valid_out = 1'b0;
    ser_shift     = 1'b0;
    done_out      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        crc_rst_out = 1'b1;
        if (accept) state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        crc_valid_out = 1'b1;
        ser_shift     = 1'b1;
        if (ser_last) state_nx = last_q ? ST_SETTLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (accept) state_nx = ST_SHIFT;
      end
      ST_SETTLE: begin
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        done_out = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign crc_bit_out = (state_q == ST_SHIFT) & ser_bit;
  assign dbg_state   = state_q;

  // The first byte of a frame counts from zero regardless of what the
  // counter still holds from the previous frame.
  assign count_base = (state_q == ST_IDLE) ? '0 : count_q;
  assign count_inc  = (&count_base) ? count_base : count_base + LEN_W'(1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_q  <= 1'b0;
      count_q <= '0;
      crc_out <= 32'h0;
      len_out <= '0;
    end else begin
      if (accept) begin
        last_q  <= byte_last_in;
        count_q <= count_inc;
      end else if (state_q == ST_IDLE) begin
        count_q <= '0;
      end
      // The engine absorbed the last bit on the edge closing the final
      // SHIFT cycle, so crc_in is stable throughout SETTLE.
      if (state_q == ST_SETTLE) begin
        crc_out <= crc_in;
        len_out <= count_q;
      end
    end
  end

`ifdef CRC_CHECK_EN
  always_ff @(posedge clk_in) begin
    if (rst_in)                     crc_ok_out <= 1'b0;
    else if (state_q == ST_SETTLE)  crc_ok_out <= (crc_in == CRC_RESIDUE);
  end
`endif

endmodule
